// File: rtl/clock_pkg.sv
// Shared definitions for the clock set/run sequencing logic.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: state encodings (also used directly as the o_sel display code),
// default timing constants, and the mode-button advance order.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_TIMEOUT_TICKS = 30;
  localparam int DEF_CNT_W         = 27;

  // Mode button advance order: RUN -> SET_HR -> SET_MIN -> RUN.
  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_RUN:    return ST_SET_HR;
      ST_SET_HR: return ST_SET_MIN;
      default:   return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Up/down button pair to step pulses: edge detection plus hold/auto-repeat.
// Latency: combinational o_step/o_dir from the current cycle (registered by the parent).
// Backpressure: none; i_clr suppresses the step and clears the hold counter.
// Ports: i_clk, i_reset (async active-low), i_up/i_dn debounced levels,
//        i_clr (drop this cycle's step, restart hold), o_step, o_dir (1 = up).
module btn_repeat #(
  parameter int HOLD_CYCLES   = clock_pkg::DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = clock_pkg::DEF_REPEAT_CYCLES,
  parameter int CNT_W         = clock_pkg::DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_up,
  input  logic i_dn,
  input  logic i_clr,
  output logic o_step,
  output logic o_dir
);

  // After a repeat fires the counter reloads so it hits HOLD_CYCLES again
  // exactly REPEAT_CYCLES cycles later.
  localparam logic [CNT_W-1:0] HOLD_VAL   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);

  logic             up_prev_q, up_prev_d;
  logic             dn_prev_q, dn_prev_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             single, up_rise, dn_rise, fire;

  always_comb begin
    up_prev_d = i_up;
    dn_prev_d = i_dn;
    single    = i_up ^ i_dn;
    // An edge only counts while the other button is low; releasing one of a
    // held pair leaves the other's previous level at 1, so no edge appears.
    up_rise   = i_up & ~up_prev_q & ~i_dn;
    dn_rise   = i_dn & ~dn_prev_q & ~i_up;
    fire      = single & (hold_q == HOLD_VAL);
    hold_d    = '0;
    if (single && !i_clr) begin
      hold_d = fire ? RELOAD_VAL : hold_q + CNT_W'(1);
    end
    o_step    = ~i_clr & (up_rise | dn_rise | fire);
    o_dir     = i_up;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      up_prev_q <= up_prev_d;
      dn_prev_q <= dn_prev_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock counter-chain sequencer: RUN timekeeping enables and SET-mode button stepping.
// Latency: all outputs registered, one cycle after the qualifying input cycle.
// Backpressure: none; enables are single-cycle pulses, counters must accept every one.
// Ports: i_clk, i_reset (async active-low), i_tick, i_btn_mode/up/dn, i_sec_roll,
//        i_min_roll -> o_sec_ena, o_min_ena, o_hr_ena, o_inc, o_sec_clr, o_sel, o_blank.
// Build option: define CLOCK_SET_CTRL_BLINK_EN to blink the selected field via o_blank.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_dn,
  input  logic       i_sec_roll,
  input  logic       i_min_roll,
  output logic       o_sec_ena,
  output logic       o_min_ena,
  output logic       o_hr_ena,
  output logic       o_inc,
  output logic       o_sec_clr,
  output logic [1:0] o_sel,
  output logic       o_blank
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            mode_prev_q, mode_prev_d;
  logic            sec_ena_q, sec_ena_d;
  logic            min_ena_q, min_ena_d;
  logic            hr_ena_q, hr_ena_d;
  logic            inc_q, inc_d;
  logic            sec_clr_q, sec_clr_d;
  logic            mode_rise, btn_clr, step, step_dir, any_btn;

  // Stepping is held off in RUN and in the cycle of a mode edge, which
  // drops any simultaneous up/down edge.
  assign btn_clr = mode_rise | (state_q == ST_RUN);

  btn_repeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_btn_repeat (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_up    (i_btn_up),
    .i_dn    (i_btn_dn),
    .i_clr   (btn_clr),
    .o_step  (step),
    .o_dir   (step_dir)
  );

  // Next state and inactivity timeout.
  always_comb begin
    mode_prev_d = i_btn_mode;
    mode_rise   = i_btn_mode & ~mode_prev_q;
    any_btn     = i_btn_mode | i_btn_up | i_btn_dn;
    state_d     = state_q;
    to_d        = to_q;
    if (mode_rise) begin
      state_d = next_mode(state_q);
      to_d    = '0;
    end else if (state_q != ST_RUN) begin
      if (any_btn) begin
        to_d = '0;
      end else if (i_tick) begin
        if (to_q == TO_W'(TIMEOUT_TICKS - 1)) begin
          to_d    = '0;
          state_d = ST_RUN;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
    end
  end

  // Enable muxing; o_inc keeps its last value outside step cycles in SET modes.
  always_comb begin
    sec_ena_d = 1'b0;
    min_ena_d = 1'b0;
    hr_ena_d  = 1'b0;
    inc_d     = inc_q;
    sec_clr_d = mode_rise & (state_q == ST_RUN);
    case (state_q)
      ST_RUN: begin
        sec_ena_d = i_tick;
        min_ena_d = i_tick & i_sec_roll;
        hr_ena_d  = i_tick & i_sec_roll & i_min_roll;
        inc_d     = 1'b1;
      end
      ST_SET_HR: begin
        hr_ena_d = step;
        if (step) inc_d = step_dir;
      end
      ST_SET_MIN: begin
        min_ena_d = step;
        if (step) inc_d = step_dir;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      to_q        <= '0;
      mode_prev_q <= 1'b0;
      sec_ena_q   <= 1'b0;
      min_ena_q   <= 1'b0;
      hr_ena_q    <= 1'b0;
      inc_q       <= 1'b1;
      sec_clr_q   <= 1'b0;
    end else begin
      to_q        <= to_d;
      mode_prev_q <= mode_prev_d;
      sec_ena_q   <= sec_ena_d;
      min_ena_q   <= min_ena_d;
      hr_ena_q    <= hr_ena_d;
      inc_q       <= inc_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  assign o_sec_ena = sec_ena_q;
  assign o_min_ena = min_ena_q;
  assign o_hr_ena  = hr_ena_q;
  assign o_inc     = inc_q;
  assign o_sec_clr = sec_clr_q;
  assign o_sel     = state_q;

`ifdef CLOCK_SET_CTRL_BLINK_EN
  logic blank_q, blank_d;

  // Blink restarts dark-free on mode change and is suppressed right after a
  // step so the newly set value is shown.
  always_comb begin
    blank_d = blank_q;
    if (mode_rise || state_d == ST_RUN) begin
      blank_d = 1'b0;
    end else if (min_ena_q || hr_ena_q) begin
      blank_d = 1'b0;
    end else if (i_tick) begin
      blank_d = ~blank_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign o_blank = blank_q;
`else
  assign o_blank = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with HOLD=8, REPEAT=4, TIMEOUT=3.
// Each step drives inputs, queues the expected registered outputs, and
// compares them one clock later.
module tb_clock_set_ctrl;
  import clock_pkg::*;

  typedef struct packed {
    logic       sec;
    logic       min;
    logic       hr;
    logic       inc;
    logic       clr;
    logic [1:0] sel;
    logic       blank;
  } out_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_btn_mode = 1'b0;
  logic       i_btn_up = 1'b0;
  logic       i_btn_dn = 1'b0;
  logic       i_sec_roll = 1'b0;
  logic       i_min_roll = 1'b0;
  logic       o_sec_ena, o_min_ena, o_hr_ena, o_inc, o_sec_clr, o_blank;
  logic [1:0] o_sel;

  out_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 i_clk = ~i_clk;

  clock_set_ctrl #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .TIMEOUT_TICKS (3),
    .CNT_W         (27)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_btn_mode (i_btn_mode),
    .i_btn_up   (i_btn_up),
    .i_btn_dn   (i_btn_dn),
    .i_sec_roll (i_sec_roll),
    .i_min_roll (i_min_roll),
    .o_sec_ena  (o_sec_ena),
    .o_min_ena  (o_min_ena),
    .o_hr_ena   (o_hr_ena),
    .o_inc      (o_inc),
    .o_sec_clr  (o_sec_clr),
    .o_sel      (o_sel),
    .o_blank    (o_blank)
  );

  function automatic out_t mk(input logic sec, input logic min, input logic hr,
                              input logic inc, input logic clr, input logic [1:0] sel);
    out_t e;
    e = {sec, min, hr, inc, clr, sel, 1'b0};
    return e;
  endfunction

  task automatic compare(input string tag, input out_t exp);
    out_t o;
    o = {o_sec_ena, o_min_ena, o_hr_ena, o_inc, o_sec_clr, o_sel, o_blank};
    n_chk++;
    assert (o === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed sec/min/hr/inc/clr/sel/blank=%b expected %b", tag, o, exp);
    end
  endtask

  // Inputs are already applied; queue the expectation for the next edge.
  task automatic chk(input string tag, input logic sec, input logic min, input logic hr,
                     input logic inc, input logic clr, input logic [1:0] sel);
    exp_q.push_back(mk(sec, min, hr, inc, clr, sel));
    @(posedge i_clk);
    #1;
    compare(tag, exp_q.pop_front());
  endtask

  task automatic press_mode(input string tag, input logic clr, input logic [1:0] sel);
    i_btn_mode = 1'b1;
    chk(tag, 1'b0, 1'b0, 1'b0, 1'b1, clr, sel);
    i_btn_mode = 1'b0;
    chk({tag, "_rel"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sel);
  endtask

  initial begin
    // Reset held
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    i_reset = 1'b1;

    // RUN: tick every 20 cycles, no rolls
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 20; c++) begin
        i_tick = (c == 0);
        chk("run_tick", (c == 0), 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
      end
    end

    // RUN with rolls
    i_sec_roll = 1'b1; i_min_roll = 1'b1; i_tick = 1'b1;
    chk("run_roll_all", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ST_RUN);
    i_tick = 1'b0;
    chk("run_roll_notick", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    i_min_roll = 1'b0; i_tick = 1'b1;
    chk("run_roll_sec", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ST_RUN);
    i_sec_roll = 1'b0; i_tick = 1'b0;
    // Up button ignored in RUN
    i_btn_up = 1'b1;
    chk("run_up_ignored", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    i_btn_up = 1'b0;
    chk("run_up_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);

    // Mode cycling
    press_mode("mode_to_hr", 1'b1, ST_SET_HR);
    for (int t = 0; t < 2; t++) begin
      i_tick = 1'b1;
      chk("sethr_tick", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_SET_HR);
      i_tick = 1'b0;
      chk("sethr_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_SET_HR);
    end
    press_mode("mode_to_min", 1'b0, ST_SET_MIN);
    press_mode("mode_to_run", 1'b0, ST_RUN);
    press_mode("mode_to_hr2", 1'b1, ST_SET_HR);
    press_mode("mode_to_min2", 1'b0, ST_SET_MIN);

    // SET_MIN up held 20 cycles: pulses at k = 0, 8, 12, 16; tick ignored
    i_btn_up = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_tick = (k == 5);
      chk("min_up_hold", 1'b0, (k == 0 || k == 8 || k == 12 || k == 16), 1'b0,
          1'b1, 1'b0, ST_SET_MIN);
    end
    i_tick = 1'b0;
    i_btn_up = 1'b0;
    chk("min_up_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_SET_MIN);

    // SET_MIN dn held 20 cycles: same timing, inc = 0 from the first pulse on
    i_btn_dn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("min_dn_hold", 1'b0, (k == 0 || k == 8 || k == 12 || k == 16), 1'b0,
          1'b0, 1'b0, ST_SET_MIN);
    end
    i_btn_dn = 1'b0;
    chk("min_dn_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_SET_MIN);

    // Mode edge together with up edge: mode wins, step dropped
    i_btn_mode = 1'b1; i_btn_up = 1'b1;
    chk("mode_beats_up", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_RUN);
    i_btn_mode = 1'b0;
    chk("mode_beats_up_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    i_btn_up = 1'b0;
    chk("mode_beats_up_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    press_mode("mode_to_hr3", 1'b1, ST_SET_HR);

    // SET_HR both buttons high: no pulses; later release of one gives no edge
    i_btn_up = 1'b1; i_btn_dn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("hr_both", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_SET_HR);
    end
    i_btn_up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("hr_dn_left", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_SET_HR);
    end
    i_btn_dn = 1'b0;
    chk("hr_both_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_SET_HR);

    // Timeout: third idle tick returns to RUN without a seconds clear
    for (int t = 0; t < 3; t++) begin
      i_tick = 1'b1;
      chk("timeout_tick", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (t == 2) ? ST_RUN : ST_SET_HR);
      i_tick = 1'b0;
      for (int c = 0; c < 2; c++) begin
        chk("timeout_gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (t == 2) ? ST_RUN : ST_SET_HR);
      end
    end

    // Reset in the middle of an auto-repeat pulse in SET_MIN
    press_mode("mode_to_hr4", 1'b1, ST_SET_HR);
    press_mode("mode_to_min4", 1'b0, ST_SET_MIN);
    i_btn_dn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("rst_pre_hold", 1'b0, (k == 0 || k == 8), 1'b0, 1'b0, 1'b0, ST_SET_MIN);
    end
    #2;
    i_reset = 1'b0;
    #1;
    compare("rst_async", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN));
    chk("rst_held", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    i_reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("post_rst_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    end
    i_btn_dn = 1'b0;
    i_tick = 1'b1;
    chk("post_rst_tick", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);
    i_tick = 1'b0;
    chk("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_RUN);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
